// File: rtl/mmio_periph_hub_pkg.sv
// mmio_periph_pkg: register offsets and 7-segment decode shared by the peripheral hub.
package mmio_periph_pkg;
  localparam logic [11:0] OFF_DIG      = 12'h000;
  localparam logic [11:0] OFF_DIG_CTRL = 12'h004;
  localparam logic [11:0] OFF_LED      = 12'h060;
  localparam logic [11:0] OFF_SW       = 12'h070;
  localparam logic [11:0] OFF_BTN      = 12'h078;
  localparam logic [11:0] OFF_BTN_EDGE = 12'h07C;
  // Bit order {A,B,C,D,E,F,G,DP}, active-low, DP always dark.
  function automatic logic [7:0] seg_decode(input logic [3:0] h);
    case (h)
      4'h0: return 8'h03;
      4'h1: return 8'h9F;
      4'h2: return 8'h25;
      4'h3: return 8'h0D;
      4'h4: return 8'h99;
      4'h5: return 8'h49;
      4'h6: return 8'h41;
      4'h7: return 8'h1F;
      4'h8: return 8'h01;
      4'h9: return 8'h09;
      4'hA: return 8'h11;
      4'hB: return 8'hC1;
      4'hC: return 8'h63;
      4'hD: return 8'h85;
      4'hE: return 8'h61;
      default: return 8'h71;
    endcase
  endfunction
endpackage

// File: rtl/mmio_periph_hub_btn_debounce.sv
// btn_debounce: synchronises one raw button and accepts a level only after it persists DB_CYCLES cycles.
module btn_debounce #(
  parameter int DB_CYCLES = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic stable,
  output logic rise
);
  localparam int CW = $clog2(DB_CYCLES);
  logic s1, s2, done;
  logic [CW-1:0] cnt;
  assign done = (s2 != stable) && (cnt == CW'(DB_CYCLES - 1));
  assign rise = done && s2;
  always_ff @(posedge clk) begin
    if (rst) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      cnt    <= '0;
      stable <= 1'b0;
    end else begin
      s1  <= raw;
      s2  <= s1;
      cnt <= (s2 == stable || done) ? '0 : cnt + 1'b1;
      if (done) stable <= s2;
    end
  end
endmodule

// File: rtl/mmio_periph_hub.sv
// mmio_periph_hub: 4 KB MMIO window serving LEDs, switches, debounced buttons and a 7-segment scanner.
module mmio_periph_hub
  import mmio_periph_pkg::*;
#(
  parameter int LED_W     = 24,
  parameter int SW_W      = 24,
  parameter int N_BTN     = 5,
  parameter int N_DIG     = 8,
  parameter int SCAN_DIV  = 20000,
  parameter int DB_CYCLES = 100000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [11:0]      addr,
  input  logic             wen,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  input  logic [SW_W-1:0]  switch,
  input  logic [N_BTN-1:0] button,
  output logic [LED_W-1:0] led,
  output logic [N_DIG-1:0] dig_en,
  output logic [7:0]       seg
);
  localparam int IW = N_DIG > 1 ? $clog2(N_DIG) : 1;
  localparam int DW = $clog2(SCAN_DIV);
  logic [4*N_DIG-1:0] dig;
  logic [N_DIG-1:0] blank;
  logic scan_en, wrap, unused_ok;
  logic [SW_W-1:0] sw1, sw2;
  logic [N_BTN-1:0] btn, rise, btn_edge;
  logic [DW-1:0] div;
  logic [IW-1:0] idx;
  logic [11:0] a;
  assign a = {addr[11:2], 2'b00};
  assign wrap = div == DW'(SCAN_DIV - 1);
  assign unused_ok = &{1'b0, addr[1:0], wdata};
  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
      .clk(clk), .rst(rst), .raw(button[i]), .stable(btn[i]), .rise(rise[i])
    );
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      led      <= '0;
      dig      <= '0;
      blank    <= '0;
      scan_en  <= 1'b1;
      sw1      <= '0;
      sw2      <= '0;
      btn_edge <= '0;
      div      <= '0;
      idx      <= '0;
      dig_en   <= '1;
      seg      <= 8'hFF;
    end else begin
      if (wen && a == OFF_DIG) dig <= wdata[4*N_DIG-1:0];
      if (wen && a == OFF_DIG_CTRL) begin
        blank   <= wdata[N_DIG-1:0];
        scan_en <= wdata[8];
      end
      if (wen && a == OFF_LED) led <= wdata[LED_W-1:0];
      sw1 <= switch;
      sw2 <= sw1;
      // A rise on the same edge as its W1C wins by being OR-ed in last.
      btn_edge <= (btn_edge & ~((wen && a == OFF_BTN_EDGE) ? wdata[N_BTN-1:0] : '0)) | rise;
      div <= wrap ? '0 : div + 1'b1;
      if (wrap) idx <= (idx == IW'(N_DIG - 1)) ? '0 : idx + 1'b1;
      dig_en <= (blank[idx] || !scan_en) ? '1 : ~(N_DIG'(1) << idx);
      seg    <= seg_decode(dig[idx*4 +: 4]);
    end
  end
  always_comb
    rdata = a == OFF_DIG      ? 32'(dig) :
            a == OFF_DIG_CTRL ? {23'b0, scan_en, 8'(blank)} :
            a == OFF_LED      ? 32'(led) :
            a == OFF_SW       ? 32'(sw2) :
            a == OFF_BTN      ? 32'(btn) :
            a == OFF_BTN_EDGE ? 32'(btn_edge) : 32'h0;
endmodule

// File: tb/tb_mmio_periph_hub.sv
// tb_mmio_periph_hub: directed stimulus with a scoreboard queue drained by a strobe-driven monitor.
`timescale 1ns/1ps
module tb_mmio_periph_hub;
  typedef struct {
    int          sel;
    string       name;
    logic [31:0] exp;
  } item_t;
  item_t sb[$];
  logic clk = 0, rst = 1, wen = 0, sample = 0, done = 0;
  logic [11:0] addr = 0;
  logic [31:0] wdata = 0;
  logic [23:0] sw = 0;
  logic [4:0] button = 0;
  logic [31:0] rdata;
  logic [23:0] led;
  logic [7:0] dig_en, seg;
  int checks = 0, errors = 0;
  logic [7:0] seg_tab [8] = '{8'h03, 8'h71, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F, 8'h01};
  always #50 clk = ~clk;
  mmio_periph_hub #(.DB_CYCLES(4), .SCAN_DIV(3)) dut (
    .clk(clk), .rst(rst), .addr(addr), .wen(wen), .wdata(wdata), .rdata(rdata),
    .switch(sw), .button(button), .led(led), .dig_en(dig_en), .seg(seg)
  );
  always @(posedge sample) begin
    while (sb.size() > 0) begin
      item_t e;
      logic [31:0] act;
      e = sb.pop_front();
      act = e.sel == 0 ? rdata : e.sel == 1 ? 32'(led) : e.sel == 2 ? 32'(dig_en) : 32'(seg);
      checks++;
      if (act !== e.exp) begin
        errors++;
        $display("FAIL %s: got %h want %h", e.name, act, e.exp);
      end
    end
  end
  initial begin
    #200000;
    if (!done) begin
      errors++;
      $display("FAIL timeout: stimulus did not complete");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  end
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic chk(input int sel, input logic [11:0] a, input string name, input logic [31:0] v);
    if (sel == 0) addr = a;
    sb.push_back('{sel: sel, name: name, exp: v});
    #1 sample = 1;
    #1 sample = 0;
  endtask
  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    addr = a;
    wdata = d;
    wen = 1;
    tick(1);
    wen = 0;
  endtask
  initial begin
    int k;
    logic [7:0] en_exp;
    tick(3);
    checks++;
    if (led !== 24'h0 || dig_en !== 8'hFF || seg !== 8'hFF) begin
      errors++;
      $display("FAIL rst_direct: led %h dig_en %h seg %h", led, dig_en, seg);
    end
    chk(1, 0, "rst_led", 0);
    chk(2, 0, "rst_dig_en", 32'hFF);
    chk(3, 0, "rst_seg", 32'hFF);
    chk(0, 12'h000, "rst_dig", 0);
    chk(0, 12'h004, "rst_dig_ctrl", 32'h100);
    chk(0, 12'h060, "rst_led_rd", 0);
    chk(0, 12'h078, "rst_btn", 0);
    chk(0, 12'h07C, "rst_btn_edge", 0);
    rst = 0;
    wr(12'h060, 32'hFFFF_FFFF);
    chk(1, 0, "led_out", 32'h00FF_FFFF);
    chk(0, 12'h060, "led_rd", 32'h00FF_FFFF);
    wr(12'h070, 32'h1234_5678);
    chk(0, 12'h070, "sw_ro", 0);
    wr(12'h100, 32'h5);
    chk(0, 12'h100, "unmapped", 0);
    sw = 24'hA5A5A5;
    tick(1);
    chk(0, 12'h070, "sw_lat1", 0);
    tick(1);
    chk(0, 12'h070, "sw_lat2", 32'h00A5_A5A5);
    button = 5'h04;
    tick(3);
    button = 0;
    tick(8);
    chk(0, 12'h078, "glitch_btn", 0);
    chk(0, 12'h07C, "glitch_edge", 0);
    button = 5'h04;
    tick(5);
    chk(0, 12'h078, "hold_btn5", 0);
    tick(1);
    chk(0, 12'h078, "hold_btn6", 32'h04);
    chk(0, 12'h07C, "hold_edge", 32'h04);
    wr(12'h07C, 32'h04);
    chk(0, 12'h07C, "w1c_edge", 0);
    chk(0, 12'h078, "w1c_btn", 32'h04);
    button = 0;
    tick(6);
    chk(0, 12'h078, "fall_btn", 0);
    chk(0, 12'h07C, "fall_no_edge", 0);
    button = 5'h04;
    tick(5);
    wr(12'h07C, 32'h04);
    chk(0, 12'h07C, "set_wins", 32'h04);
    rst = 1;
    tick(2);
    rst = 0;
    wr(12'h000, 32'h8765_43F0);
    wr(12'h004, 32'h104);
    for (int c = 1; c <= 24; c++) begin
      if (c > 1) tick(1);
      k = (c / 3) % 8;
      en_exp = 8'h01 << k;
      en_exp = k == 2 ? 8'hFF : ~en_exp;
      chk(2, 0, "scan_dig_en", {24'b0, en_exp});
      chk(3, 0, "scan_seg", {24'b0, seg_tab[k]});
    end
    button = 0;
    tick(3);
    rst = 1;
    button = 5'h04;
    tick(1);
    chk(2, 0, "mid_rst_dig_en", 32'hFF);
    chk(3, 0, "mid_rst_seg", 32'hFF);
    chk(0, 12'h078, "mid_rst_btn", 0);
    chk(0, 12'h07C, "mid_rst_edge", 0);
    chk(0, 12'h000, "mid_rst_dig", 0);
    rst = 0;
    tick(1);
    chk(2, 0, "post_rst_d0a", 32'hFE);
    chk(3, 0, "post_rst_seg", 32'h03);
    tick(1);
    chk(2, 0, "post_rst_d0b", 32'hFE);
    tick(1);
    chk(2, 0, "post_rst_d0c", 32'hFE);
    tick(1);
    chk(2, 0, "post_rst_d1", 32'hFD);
    tick(1);
    chk(0, 12'h078, "post_rst_btn5", 0);
    tick(1);
    chk(0, 12'h078, "post_rst_btn6", 32'h04);
    chk(0, 12'h07C, "post_rst_edge", 32'h04);
    tick(2);
    done = 1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $display(errors == 0 ? "PASS" : "FAIL");
    $finish;
  end
endmodule
